// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB lane count, widths and broadcast result record
package cdb_pkg;
    localparam int CDB_LANES = 4;
    localparam int ROBEN_W   = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [ROBEN_W-1:0] roben;
        logic [DATA_W-1:0]  data;
        logic               is_branch;
        logic               decision;
        logic               exception;
    } cdb_result_t;

    localparam logic [ROBEN_W-1:0] CDB_IDLE_TAG = '0;
endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer-side handshake and four CDB broadcast lanes
interface cdb_arbiter_if #(
    parameter int NUM_SRC = 6,
    parameter int ROBEN_W = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC-1:0]         src_ready;
    logic [NUM_SRC*ROBEN_W-1:0] src_roben;
    logic [NUM_SRC*DATA_W-1:0]  src_data;
    logic [NUM_SRC-1:0]         src_is_branch;
    logic [NUM_SRC-1:0]         src_branch_decision;
    logic [NUM_SRC-1:0]         src_exception;

    logic [ROBEN_W-1:0] CDB_ROBEN1, CDB_ROBEN2, CDB_ROBEN3, CDB_ROBEN4;
    logic [DATA_W-1:0]  CDB_Write_Data1, CDB_Write_Data2, CDB_Write_Data3, CDB_Write_Data4;
    logic               CDB_Branch_Decision1, CDB_Branch_Decision2;
    logic               CDB_Branch_Decision3, CDB_Branch_Decision4;
    logic               CDB_EXCEPTION1, CDB_EXCEPTION2, CDB_EXCEPTION3, CDB_EXCEPTION4;

    modport master (
        output src_valid, src_roben, src_data, src_is_branch, src_branch_decision, src_exception,
        input  src_ready,
        input  CDB_ROBEN1, CDB_ROBEN2, CDB_ROBEN3, CDB_ROBEN4,
        input  CDB_Write_Data1, CDB_Write_Data2, CDB_Write_Data3, CDB_Write_Data4,
        input  CDB_Branch_Decision1, CDB_Branch_Decision2, CDB_Branch_Decision3, CDB_Branch_Decision4,
        input  CDB_EXCEPTION1, CDB_EXCEPTION2, CDB_EXCEPTION3, CDB_EXCEPTION4
    );

    modport slave (
        input  src_valid, src_roben, src_data, src_is_branch, src_branch_decision, src_exception,
        output src_ready,
        output CDB_ROBEN1, CDB_ROBEN2, CDB_ROBEN3, CDB_ROBEN4,
        output CDB_Write_Data1, CDB_Write_Data2, CDB_Write_Data3, CDB_Write_Data4,
        output CDB_Branch_Decision1, CDB_Branch_Decision2, CDB_Branch_Decision3, CDB_Branch_Decision4,
        output CDB_EXCEPTION1, CDB_EXCEPTION2, CDB_EXCEPTION3, CDB_EXCEPTION4
    );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// rtl/cdb_rr_arbiter.sv - combinational round-robin picker of up to four requesters onto CDB lanes
module cdb_rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = 6,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_SRC-1:0]      req_i,
    input  logic [NUM_SRC-1:0]      is_branch_i,
    input  logic [PTR_W-1:0]        rr_ptr_i,
    output logic [NUM_SRC-1:0]      grant_o,
    output logic [NUM_SRC-1:0][1:0] lane_o,
    output logic [PTR_W-1:0]        rr_ptr_next_o
);
    always_comb begin
        logic [CDB_LANES-1:0] used;
        logic [PTR_W-1:0]     idx;
        logic [1:0]           ln;
        logic                 found;
        used          = '0;
        idx           = '0;
        ln            = '0;
        found         = 1'b0;
        grant_o       = '0;
        lane_o        = '0;
        rr_ptr_next_o = rr_ptr_i;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx   = PTR_W'((int'(rr_ptr_i) + k) % NUM_SRC);
            found = 1'b0;
            ln    = '0;
            // Lowest free lane wins; lane 2 (index 1) is skipped for branches since it clears speculation.
            for (int l = CDB_LANES - 1; l >= 0; l--) begin
                if (!used[l] && !(l == 1 && is_branch_i[idx])) begin
                    found = 1'b1;
                    ln    = 2'(l);
                end
            end
            if (req_i[idx] && found) begin
                used[ln]      = 1'b1;
                grant_o[idx]  = 1'b1;
                lane_o[idx]   = ln;
                rr_ptr_next_o = (idx == PTR_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB transmitter: per-source holding slots, RR lane arbitration, registered lanes (option CDB_BYPASS_EN)
module cdb_arbiter #(
    parameter int NUM_SRC = 6,
    parameter int ROBEN_W = 5,
    parameter int DATA_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         FLUSH_Flag,
    cdb_arbiter_if.slave bus
);
    import cdb_pkg::*;

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    cdb_result_t slot_q [NUM_SRC];
    cdb_result_t slot_d [NUM_SRC];
    cdb_result_t in_res [NUM_SRC];
    cdb_result_t cand   [NUM_SRC];
    cdb_result_t lane_q [CDB_LANES];
    cdb_result_t lane_d [CDB_LANES];

    logic [NUM_SRC-1:0]      held_q, held_d;
    logic [NUM_SRC-1:0]      tag_nz, byp, req, cand_br, grant, take;
    logic [NUM_SRC-1:0][1:0] lane_sel;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;

    always_comb begin
        tag_nz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            in_res[i].roben     = bus.src_roben[i*ROBEN_W +: ROBEN_W];
            in_res[i].data      = bus.src_data[i*DATA_W +: DATA_W];
            in_res[i].is_branch = bus.src_is_branch[i];
            in_res[i].decision  = bus.src_branch_decision[i];
            in_res[i].exception = bus.src_exception[i];
            tag_nz[i]           = in_res[i].roben != CDB_IDLE_TAG;
        end
    end

`ifdef CDB_BYPASS_EN
    // An empty slot's arriving result competes in the same cycle and skips the slot if it wins.
    assign byp = ~held_q & bus.src_valid & tag_nz;
`else
    assign byp = '0;
`endif

    always_comb begin
        cand_br = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i]    = held_q[i] ? slot_q[i] : in_res[i];
            cand_br[i] = cand[i].is_branch;
        end
    end

    assign req = (held_q | byp) & {NUM_SRC{~FLUSH_Flag}};

    cdb_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i         (req),
        .is_branch_i   (cand_br),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .lane_o        (lane_sel),
        .rr_ptr_next_o (rr_ptr_d)
    );

    assign bus.src_ready = FLUSH_Flag ? '1 : (~held_q | grant);
    assign take   = bus.src_valid & bus.src_ready & tag_nz & ~(grant & byp) & {NUM_SRC{~FLUSH_Flag}};
    assign held_d = FLUSH_Flag ? '0 : ((held_q & ~grant) | take);

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            slot_d[i] = take[i] ? in_res[i] : slot_q[i];
        end
        for (int l = 0; l < CDB_LANES; l++) begin
            lane_d[l] = '0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                lane_d[lane_sel[i]] = cand[i];
            end
        end
        lane_d[1].decision = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q   <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_q[i] <= '0;
            end
            for (int l = 0; l < CDB_LANES; l++) begin
                lane_q[l] <= '0;
            end
        end else begin
            held_q   <= held_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_q[i] <= slot_d[i];
            end
            for (int l = 0; l < CDB_LANES; l++) begin
                lane_q[l] <= lane_d[l];
            end
        end
    end

    assign bus.CDB_ROBEN1           = lane_q[0].roben;
    assign bus.CDB_ROBEN2           = lane_q[1].roben;
    assign bus.CDB_ROBEN3           = lane_q[2].roben;
    assign bus.CDB_ROBEN4           = lane_q[3].roben;
    assign bus.CDB_Write_Data1      = lane_q[0].data;
    assign bus.CDB_Write_Data2      = lane_q[1].data;
    assign bus.CDB_Write_Data3      = lane_q[2].data;
    assign bus.CDB_Write_Data4      = lane_q[3].data;
    assign bus.CDB_Branch_Decision1 = lane_q[0].decision;
    assign bus.CDB_Branch_Decision2 = lane_q[1].decision;
    assign bus.CDB_Branch_Decision3 = lane_q[2].decision;
    assign bus.CDB_Branch_Decision4 = lane_q[3].decision;
    assign bus.CDB_EXCEPTION1       = lane_q[0].exception;
    assign bus.CDB_EXCEPTION2       = lane_q[1].exception;
    assign bus.CDB_EXCEPTION3       = lane_q[2].exception;
    assign bus.CDB_EXCEPTION4       = lane_q[3].exception;
endmodule
